// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg : shared types, timing defaults and helpers for lcd_bus_engine
// Rev 1.0
// ============================================================================
package lcd_pkg;

  localparam int NIBBLE_8BIT = 0;
  localparam int NIBBLE_4BIT = 1;

  localparam int DEF_SETUP_CYC    = 2;
  localparam int DEF_EN_HIGH_CYC  = 12;
  localparam int DEF_RECOVER_CYC  = 15;
  localparam int DEF_BUSY_TIMEOUT = 1023;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_POLL = 2'd1;
  localparam state_t ST_XFER = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic       oe;
    logic [7:0] db;
  } pins_t;

  // Idle bus doubles as the status-read setting: rs=0, rw=1, bus released.
  localparam pins_t PINS_IDLE = '{rs: 1'b0, rw: 1'b1, oe: 1'b0, db: 8'h00};

  function automatic int cnt_width(input int p, input int t);
    int m;
    m = (p > t) ? p : t;
    return $clog2(m + 1);
  endfunction

  function automatic pins_t access_pins(input logic we, input logic rs,
                                        input logic [7:0] d, input bit nib4);
    pins_t p;
    p.rs = rs;
    p.rw = ~we;
    p.oe = we;
    if (!we)       p.db = 8'h00;
    else if (nib4) p.db = {d[7:4], 4'h0};
    else           p.db = d;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_pulse_gen.sv
`default_nettype none
// ============================================================================
// lcd_pulse_gen : one EN pulse (setup low, EN high, recover low)
// Rev 1.0
// ============================================================================
module lcd_pulse_gen #(
  parameter int SETUP_CYC   = 2,
  parameter int EN_HIGH_CYC = 12,
  parameter int RECOVER_CYC = 15,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic en_o,
  output logic sample_o,
  output logic done_o
);

  localparam int P = SETUP_CYC + EN_HIGH_CYC + RECOVER_CYC;
  localparam logic [CNT_W-1:0] C_EN_ON   = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] C_EN_LAST = CNT_W'(SETUP_CYC + EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(P - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;

  assign sample_o = active_q && (cnt_q == C_EN_LAST);
  assign done_o   = active_q && (cnt_q == C_LAST);
  assign en_o     = en_q;

  // A start on the done cycle restarts without a gap cycle.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (done_o) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (active_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    en_d = active_d && (cnt_d >= C_EN_ON) && (cnt_d <= C_EN_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_bus_engine.sv
`default_nettype none
// ============================================================================
// lcd_bus_engine : HD44780 bus timing engine, 8/4-bit, optional busy polling
// Rev 1.0
// ============================================================================
module lcd_bus_engine
  import lcd_pkg::*;
#(
  parameter int NIBBLE_MODE  = NIBBLE_8BIT,
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int EN_HIGH_CYC  = DEF_EN_HIGH_CYC,
  parameter int RECOVER_CYC  = DEF_RECOVER_CYC,
  parameter int BUSY_POLL    = 0,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic       ready,
  input  logic       we,
  input  logic       rs,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       busy_timeout,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_db_o,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_i
);

  // Clamp so no phase can collapse to zero length.
  localparam int  S_C     = (SETUP_CYC    < 1) ? 1 : SETUP_CYC;
  localparam int  H_C     = (EN_HIGH_CYC  < 1) ? 1 : EN_HIGH_CYC;
  localparam int  R_C     = (RECOVER_CYC  < 1) ? 1 : RECOVER_CYC;
  localparam int  BT_C    = (BUSY_TIMEOUT < 1) ? 1 : BUSY_TIMEOUT;
  localparam int  CNT_W   = cnt_width(S_C + H_C + R_C, BT_C);
  localparam bit  IS_4BIT = (NIBBLE_MODE == NIBBLE_4BIT);
  localparam logic [CNT_W-1:0] C_POLL_LAST = CNT_W'(BT_C - 1);

  state_t           state_q, state_d;
  logic             nib_q, nib_d;
  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic             we_q, we_d, rs_q, rs_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rbuf_q, rbuf_d;
  logic             stat_busy_q, stat_busy_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             bto_q, bto_d;
  pins_t            pins_q, pins_d;

  logic pulse_start, pulse_en, pulse_sample, pulse_done;
  logic accept;

  lcd_pulse_gen #(
    .SETUP_CYC   (S_C),
    .EN_HIGH_CYC (H_C),
    .RECOVER_CYC (R_C),
    .CNT_W       (CNT_W)
  ) u_pulse (
    .clk      (clk),
    .rst      (rst),
    .start_i  (pulse_start),
    .en_o     (pulse_en),
    .sample_o (pulse_sample),
    .done_o   (pulse_done)
  );

  assign ready        = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept       = req && ready;
  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;
  assign busy_timeout = bto_q;
  assign lcd_rs       = pins_q.rs;
  assign lcd_rw       = pins_q.rw;
  assign lcd_db_oe    = pins_q.oe;
  assign lcd_db_o     = pins_q.db;
  assign lcd_en       = pulse_en;

  always_comb begin
    state_d     = state_q;
    nib_d       = nib_q;
    poll_cnt_d  = poll_cnt_q;
    we_d        = we_q;
    rs_d        = rs_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    stat_busy_d = stat_busy_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    bto_d       = bto_q;
    pins_d      = pins_q;
    pulse_start = 1'b0;

    // Busy flag lives in DB7 of the first nibble; second status nibble is dropped.
    if (pulse_sample) begin
      if (state_q == ST_POLL) begin
        if (!nib_q) stat_busy_d = lcd_db_i[7];
      end else if (!IS_4BIT) begin
        rbuf_d = lcd_db_i;
      end else if (!nib_q) begin
        rbuf_d[7:4] = lcd_db_i[7:4];
      end else begin
        rbuf_d[3:0] = lcd_db_i[7:4];
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          we_d        = we;
          rs_d        = rs;
          wdata_d     = wdata;
          bto_d       = 1'b0;
          poll_cnt_d  = '0;
          nib_d       = 1'b0;
          pulse_start = 1'b1;
          if ((BUSY_POLL != 0) && (we || rs)) begin
            state_d = ST_POLL;
            pins_d  = PINS_IDLE;
          end else begin
            state_d = ST_XFER;
            pins_d  = access_pins(we, rs, wdata, IS_4BIT);
          end
        end
      end
      ST_POLL: begin
        if (pulse_done) begin
          pulse_start = 1'b1;
          if (IS_4BIT && !nib_q) begin
            nib_d = 1'b1;
          end else begin
            nib_d = 1'b0;
            if (!stat_busy_q || (poll_cnt_q == C_POLL_LAST)) begin
              bto_d   = stat_busy_q;
              state_d = ST_XFER;
              pins_d  = access_pins(we_q, rs_q, wdata_q, IS_4BIT);
            end else begin
              poll_cnt_d = poll_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_XFER: begin
        if (pulse_done) begin
          if (IS_4BIT && !nib_q) begin
            nib_d       = 1'b1;
            pulse_start = 1'b1;
            if (we_q) pins_d.db = {wdata_q[3:0], 4'h0};
          end else begin
            nib_d   = 1'b0;
            state_d = ST_DONE;
            pins_d  = PINS_IDLE;
            if (!we_q) begin
              rdata_d  = rbuf_q;
              rvalid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      nib_q       <= 1'b0;
      poll_cnt_q  <= '0;
      we_q        <= 1'b0;
      rs_q        <= 1'b0;
      wdata_q     <= 8'h00;
      rbuf_q      <= 8'h00;
      stat_busy_q <= 1'b0;
      rdata_q     <= 8'h00;
      rvalid_q    <= 1'b0;
      bto_q       <= 1'b0;
      pins_q      <= PINS_IDLE;
    end else begin
      state_q     <= state_d;
      nib_q       <= nib_d;
      poll_cnt_q  <= poll_cnt_d;
      we_q        <= we_d;
      rs_q        <= rs_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      stat_busy_q <= stat_busy_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      bto_q       <= bto_d;
      pins_q      <= pins_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_engine.sv
`default_nettype none
// ============================================================================
// tb_lcd_bus_engine : directed bench for lcd_bus_engine (four configurations)
// Rev 1.0
// ============================================================================
module tb_lcd_bus_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       we  = 1'b0;
  logic       rs  = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] db_i  = 8'h00;

  // index 0: 8-bit, 1: 4-bit, 2: 8-bit polled, 3: 8-bit polled timeout=4
  logic       ready_a [4];
  logic       rvalid_a[4];
  logic       bto_a   [4];
  logic       en_a    [4];
  logic       rw_a    [4];
  logic       rsp_a   [4];
  logic       oe_a    [4];
  logic [7:0] rdata_a [4];
  logic [7:0] db_a    [4];

  int total = 0;
  int bad   = 0;

  localparam logic [22:0] RST_SNAP = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};

  always #5 clk = ~clk;

  lcd_bus_engine u_8 (
    .clk(clk), .rst(rst), .req(req), .ready(ready_a[0]), .we(we), .rs(rs), .wdata(wdata),
    .rdata(rdata_a[0]), .rvalid(rvalid_a[0]), .busy_timeout(bto_a[0]),
    .lcd_rs(rsp_a[0]), .lcd_rw(rw_a[0]), .lcd_en(en_a[0]), .lcd_db_o(db_a[0]),
    .lcd_db_oe(oe_a[0]), .lcd_db_i(db_i));

  lcd_bus_engine #(.NIBBLE_MODE(1)) u_4 (
    .clk(clk), .rst(rst), .req(req), .ready(ready_a[1]), .we(we), .rs(rs), .wdata(wdata),
    .rdata(rdata_a[1]), .rvalid(rvalid_a[1]), .busy_timeout(bto_a[1]),
    .lcd_rs(rsp_a[1]), .lcd_rw(rw_a[1]), .lcd_en(en_a[1]), .lcd_db_o(db_a[1]),
    .lcd_db_oe(oe_a[1]), .lcd_db_i(db_i));

  lcd_bus_engine #(.BUSY_POLL(1)) u_p (
    .clk(clk), .rst(rst), .req(req), .ready(ready_a[2]), .we(we), .rs(rs), .wdata(wdata),
    .rdata(rdata_a[2]), .rvalid(rvalid_a[2]), .busy_timeout(bto_a[2]),
    .lcd_rs(rsp_a[2]), .lcd_rw(rw_a[2]), .lcd_en(en_a[2]), .lcd_db_o(db_a[2]),
    .lcd_db_oe(oe_a[2]), .lcd_db_i(db_i));

  lcd_bus_engine #(.BUSY_POLL(1), .BUSY_TIMEOUT(4)) u_t (
    .clk(clk), .rst(rst), .req(req), .ready(ready_a[3]), .we(we), .rs(rs), .wdata(wdata),
    .rdata(rdata_a[3]), .rvalid(rvalid_a[3]), .busy_timeout(bto_a[3]),
    .lcd_rs(rsp_a[3]), .lcd_rw(rw_a[3]), .lcd_en(en_a[3]), .lcd_db_o(db_a[3]),
    .lcd_db_oe(oe_a[3]), .lcd_db_i(db_i));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] snap(input int n);
    return {ready_a[n], rvalid_a[n], bto_a[n], en_a[n], rw_a[n], rsp_a[n], oe_a[n],
            db_a[n], rdata_a[n]};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; rs = 1'b0; wdata = 8'h00; db_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Called one step after the accept edge; returns inside the DONE cycle (i=30).
  task automatic track8(input string tag, input logic exp_rs, input logic [7:0] exp_db);
    for (int i = 1; i <= 30; i++) begin
      if (i > 1) next_cyc();
      if (i < 30) begin
        check($sformatf("%s_en_%0d", tag, i), en_a[0], (i >= 3 && i <= 14));
        check($sformatf("%s_bus_%0d", tag, i), {ready_a[0], rsp_a[0], rw_a[0], oe_a[0], db_a[0]},
              {1'b0, exp_rs, 1'b0, 1'b1, exp_db});
      end else begin
        check($sformatf("%s_done", tag), {ready_a[0], rsp_a[0], rw_a[0], oe_a[0], en_a[0]},
              {1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      end
    end
  endtask

  // Four status reads (i=1..116), write of 0x3C (i=117..145), DONE at i=146.
  task automatic poll_track(input int n, input string tag, input int busy_reads,
                            input logic exp_bto);
    int   rises;
    logic prev;
    rises = 0;
    prev  = 1'b0;
    for (int i = 1; i <= 146; i++) begin
      if (i > 1) next_cyc();
      db_i = (i <= busy_reads * 29) ? 8'h80 : 8'h00;
      if (en_a[n] && !prev) rises++;
      prev = en_a[n];
      if (i <= 116)
        check($sformatf("%s_stat_%0d", tag, i), {ready_a[n], rsp_a[n], rw_a[n], oe_a[n], db_a[n]},
              {1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
      else if (i <= 145)
        check($sformatf("%s_wr_%0d", tag, i), {ready_a[n], rsp_a[n], rw_a[n], oe_a[n], db_a[n]},
              {1'b0, 1'b1, 1'b0, 1'b1, 8'h3C});
      else
        check($sformatf("%s_done", tag), {ready_a[n], rsp_a[n], rw_a[n], oe_a[n], bto_a[n]},
              {1'b1, 1'b0, 1'b1, 1'b0, exp_bto});
    end
    check($sformatf("%s_pulses", tag), rises, 5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    do_reset();
    for (int n = 0; n < 4; n++) check($sformatf("reset_%0d", n), snap(n), RST_SNAP);

    // 8-bit write, rs=1, 0x41
    req = 1'b1; we = 1'b1; rs = 1'b1; wdata = 8'h41;
    next_cyc();
    req = 1'b0;
    track8("w41", 1'b1, 8'h41);

    // 4-bit read, nibbles 0xA then 0x5
    do_reset();
    db_i = 8'hA0; req = 1'b1; we = 1'b0; rs = 1'b1;
    next_cyc();
    req = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (i > 1) next_cyc();
      db_i = (i <= 29) ? 8'hA0 : 8'h50;
      check($sformatf("rd4_en_%0d", i), en_a[1], ((i >= 3 && i <= 14) || (i >= 32 && i <= 43)));
      check($sformatf("rd4_rvalid_%0d", i), rvalid_a[1], (i == 59));
      if (i <= 59) check($sformatf("rd4_ready_%0d", i), ready_a[1], (i == 59));
      if (i <= 58)
        check($sformatf("rd4_bus_%0d", i), {rsp_a[1], rw_a[1], oe_a[1], db_a[1]},
              {1'b1, 1'b1, 1'b0, 8'h00});
      if (i == 59) check("rd4_rdata", rdata_a[1], 8'hA5);
    end

    // Busy for three status reads, idle on the fourth
    do_reset();
    db_i = 8'h80; req = 1'b1; we = 1'b1; rs = 1'b1; wdata = 8'h3C;
    next_cyc();
    req = 1'b0;
    poll_track(2, "poll", 3, 1'b0);

    // Busy stuck, timeout after four reads
    do_reset();
    db_i = 8'h80; req = 1'b1; we = 1'b1; rs = 1'b1; wdata = 8'h3C;
    next_cyc();
    req = 1'b0;
    poll_track(3, "tmo", 1000, 1'b1);
    req = 1'b1; we = 1'b0; rs = 1'b0;
    next_cyc();
    req = 1'b0;
    check("tmo_clear", bto_a[3], 1'b0);
    repeat (29) next_cyc();
    check("tmo_st_rvalid", rvalid_a[3], 1'b1);
    check("tmo_st_rdata", rdata_a[3], 8'h80);

    // Reset while EN is high, then a fresh write
    do_reset();
    req = 1'b1; we = 1'b1; rs = 1'b1; wdata = 8'h55;
    next_cyc();
    req = 1'b0;
    repeat (4) next_cyc();
    check("mid_en_high", en_a[0], 1'b1);
    rst = 1'b1;
    next_cyc();
    check("mid_rst_snap", snap(0), RST_SNAP);
    rst = 1'b0; req = 1'b1; we = 1'b1; rs = 1'b0; wdata = 8'h12;
    next_cyc();
    req = 1'b0;
    track8("post_rst", 1'b0, 8'h12);

    // Back-to-back writes with req held high; inputs changed mid-flight are ignored
    do_reset();
    req = 1'b1; we = 1'b1; rs = 1'b1; wdata = 8'h11;
    next_cyc();
    we = 1'b0; rs = 1'b0; wdata = 8'hEE;
    track8("b2b_1", 1'b1, 8'h11);
    we = 1'b1; rs = 1'b1; wdata = 8'h22;
    next_cyc();
    track8("b2b_2", 1'b1, 8'h22);
    req = 1'b0;
    next_cyc();
    check("b2b_idle", ready_a[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
